inst_fetch_buf: RTL and testbench
=================================

# inst_fetch_buf

Instruction fetch stage with a prefetch FIFO. It sits between the program memory (`fake_ram`) and the instruction decoder (`inst_deco`). It owns the fetch PC, issues one word read per cycle to memory, and buffers the returned instructions with their addresses. It presents them to the decoder through a valid/ready handshake and discards everything on a taken branch (flush).

## Interface

Parameters:
- `DEPTH`, 4: FIFO entries; power of two, 2..16.
- `AW`, 16: address width.
- `DW`, 16: instruction width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `en`  in  1  fetch enable (driven by ENFETCH); low = no new memory requests.
- `flush`  in  1  taken branch; redirect fetch.
- `flush_pc`  in  AW  branch target, sampled when `flush`=1.
- `mem_req`  out  1  read request this cycle.
- `mem_addr`  out  AW  read address (word address).
- `mem_data`  in  DW  read data, valid exactly one cycle after `mem_req`.
- `inst_out`  out  DW  head instruction.
- `inst_pc`  out  AW  address of head instruction.
- `inst_valid`  out  1  head entry valid.
- `inst_ready`  in  1  decoder accepts head.
- `count`  out  $clog2(DEPTH)+1  occupied FIFO entries.

## Operation

- **State.**
  - `fpc` is the fetch PC.
  - FIFO of DEPTH entries {inst, pc}, with rd/wr pointers and count.
  - One in-flight flag `pend` with its address `pend_pc`.
- **Request rule.**
  - `mem_req = en & ~flush & (count + pend - pop < DEPTH)`, where `pop = inst_valid & inst_ready`.
  - `mem_addr = fpc`.
  - On request: `fpc <= fpc + 1`, wrapping 0xFFFF→0x0000. Also `pend <= 1` and `pend_pc <= fpc`.
  - On no request: `pend <= 0`.
- **Response.** When `pend`=1 and no flush, {`mem_data`, `pend_pc`} is written at the wr pointer at the end of that cycle.
- **Pop.** When `pop`=1, the rd pointer advances. Push and pop in the same cycle leaves `count` unchanged. No overflow is possible, by construction of the request rule.
- **Flush** has priority over all other events in the cycle:
  - `fpc <= flush_pc`.
  - FIFO is emptied (pointers 0, `count` 0).
  - `pend <= 0`; any response arriving this cycle is dropped.
  - A pop in the same cycle is still counted as accepted by the decoder, but has no effect on state.
  - `mem_req` is 0 in the flush cycle.
  - The first request to `flush_pc` issues on the next cycle.
- **`en` low.**
  - No new requests are issued.
  - A pending response is still captured.
  - Popping continues.
- **Reset** (`reset`=0 at an edge), including mid-operation:
  - `fpc`=0, FIFO empty, `pend`=0.
  - Outputs: `mem_req`=0, `mem_addr`=0, `inst_valid`=0, `inst_out`=0, `inst_pc`=0, `count`=0.
- **Empty FIFO.** `inst_out`/`inst_pc` are held at 0 whenever `inst_valid`=0. This does not apply to the bypass case.

## Timing

- Cycle 0 is the first cycle with `reset`=1 and `en`=1: `mem_req`=1, `mem_addr`=0.
- Cycle 1: `mem_data` carries word 0. The request for address 1 issues.
- Without bypass: `inst_valid`=1 from cycle 2, with `inst_pc`=0. Fetch-to-decode latency is 2 cycles.
- Sustained throughput is 1 instruction/cycle while `inst_ready`=1.
- Full FIFO: when `count`=DEPTH and `inst_ready`=0, `mem_req` deasserts. After the first pop it resumes in the same cycle as that pop.
- Flush in cycle F:
  - First request to `flush_pc` in F+1.
  - `inst_valid` at F+3 without bypass, F+2 with bypass.

## Configuration

Macro `FETCH_BYPASS_EN`.

- **Defined:**
  - If the FIFO is empty and a response arrives (`pend`=1, no flush), `inst_out`=`mem_data`, `inst_pc`=`pend_pc` and `inst_valid`=1 in that same cycle.
  - If accepted (`inst_ready`=1), the entry is not written into the FIFO.
  - Latency is 1 cycle; this adds a combinational path from `mem_data` to `inst_out`.
- **Undefined:** all instructions pass through the FIFO registers. Latency is 2 cycles and there is no combinational memory-to-decoder path.

## Test plan

- **Reset then stream.** Release `reset`, `en`=1, `inst_ready`=1, memory word n = 0x1000+n → decoder receives 0x1000, 0x1001, 0x1002… with `inst_pc` 0,1,2… The first `inst_valid` is at cycle 2, or cycle 1 with `FETCH_BYPASS_EN`.
- **Backpressure / full.** Hold `inst_ready`=0 with DEPTH=4 → `count` reaches 4 and `mem_req`=0. Release → instructions arrive in order with no loss or duplication, and `mem_req` resumes in the first pop cycle.
- **Flush with pending response.** Assert `flush`, `flush_pc`=0x0040, while `count`=3 and `pend`=1 → `count`=0 next cycle and the pending word is dropped. The next `mem_addr` is 0x0040, and the first delivered `inst_pc` is 0x0040.
- **Wrap-around.** Flush to 0xFFFE → delivered `inst_pc` sequence is 0xFFFE, 0xFFFF, 0x0000.
- **`en` gating.** Drop `en` for 5 cycles mid-stream → `mem_req`=0 from that cycle. The in-flight word is still delivered, and the sequence resumes without a gap in addresses.
- **Reset mid-operation.** Assert `reset`=0 with `count`=2 → at the next edge all outputs are 0 and `count`=0. After release, fetch restarts at address 0.

Source files
------------

// File: rtl/inst_fetch_buf.sv
// Fetch stage: owns fetch PC, one word read per cycle, prefetch FIFO of {inst, pc} toward the decoder.
// Latency 2 cycles request-to-decode (1 with FETCH_BYPASS_EN defined: empty-FIFO response bypass).
// Backpressure: requests stop when buffered + in-flight words would exceed DEPTH; flush drops everything.
module inst_fetch_buf #(
  parameter int DEPTH = 4,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_pc,
  output logic                     mem_req,
  output logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_data,
  output logic [DW-1:0]            inst_out,
  output logic [AW-1:0]            inst_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fpc_q, fpc_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] pend_pc_q, pend_pc_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [DW-1:0] fifo_inst_q [DEPTH];
  logic [DW-1:0] fifo_inst_d [DEPTH];
  logic [AW-1:0] fifo_pc_q   [DEPTH];
  logic [AW-1:0] fifo_pc_d   [DEPTH];

  logic          fifo_empty;
  logic          rsp_vld;
  logic          push;
  logic          pop;
  logic          fifo_pop;
  logic          req;
  logic [CW:0]   occ;

  always_comb begin
    fifo_empty = (count_q == '0);
    rsp_vld    = pend_q & ~flush;
    inst_valid = ~fifo_empty;
    inst_out   = fifo_empty ? '0 : fifo_inst_q[rd_ptr_q];
    inst_pc    = fifo_empty ? '0 : fifo_pc_q[rd_ptr_q];
`ifdef FETCH_BYPASS_EN
    if (fifo_empty && rsp_vld) begin
      inst_valid = 1'b1;
      inst_out   = mem_data;
      inst_pc    = pend_pc_q;
    end
    // A bypassed word that the decoder takes never lands in the FIFO.
    push = rsp_vld & ~(fifo_empty & inst_ready);
`else
    push = rsp_vld;
`endif
    pop      = inst_valid & inst_ready;
    fifo_pop = pop & ~fifo_empty;
    // Occupancy seen by the request rule counts the in-flight word and credits this cycle's pop.
    occ      = {1'b0, count_q} + {{CW{1'b0}}, pend_q} - {{CW{1'b0}}, pop};
    req      = reset & en & ~flush & (occ < (CW+1)'(DEPTH));
    mem_req  = req;
    mem_addr = fpc_q;
    count    = count_q;
  end

  always_comb begin
    fpc_d       = fpc_q;
    pend_d      = pend_q;
    pend_pc_d   = pend_pc_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    fifo_inst_d = fifo_inst_q;
    fifo_pc_d   = fifo_pc_q;
    if (flush) begin
      fpc_d    = flush_pc;
      pend_d   = 1'b0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      pend_d = req;
      if (req) begin
        fpc_d     = fpc_q + 1'b1;
        pend_pc_d = fpc_q;
      end
      if (push) begin
        fifo_inst_d[wr_ptr_q] = mem_data;
        fifo_pc_d[wr_ptr_q]   = pend_pc_q;
        wr_ptr_d              = wr_ptr_q + 1'b1;
      end
      if (fifo_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(fifo_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fpc_q       <= '0;
      pend_q      <= 1'b0;
      pend_pc_q   <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      fifo_inst_q <= '{default: '0};
      fifo_pc_q   <= '{default: '0};
    end else begin
      fpc_q       <= fpc_d;
      pend_q      <= pend_d;
      pend_pc_q   <= pend_pc_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      fifo_inst_q <= fifo_inst_d;
      fifo_pc_q   <= fifo_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch_buf.sv
// Directed bench for inst_fetch_buf (DEPTH=4): memory word n holds 0x1000+n, delivered words are scoreboarded.
module tb_inst_fetch_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        flush;
  logic [15:0] flush_pc;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_data;
  logic [15:0] inst_out;
  logic [15:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [2:0]  count;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_pc = 16'h0000;

  inst_fetch_buf #(.DEPTH(4), .AW(16), .DW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .flush      (flush),
    .flush_pc   (flush_pc),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .inst_out   (inst_out),
    .inst_pc    (inst_pc),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory answers one cycle after a request; sampled mid-cycle, driven just after the edge.
  task automatic tick();
    logic        r;
    logic [15:0] a;
    @(negedge clk);
    r = mem_req;
    a = mem_addr;
    @(posedge clk);
    #1;
    mem_data = r ? 16'h1000 + a : 16'hDEAD;
  endtask

  task automatic step();
    logic [15:0] exp_inst;
    #1;
    if (inst_valid && inst_ready) begin
      exp_inst = 16'h1000 + exp_pc;
      chk("pop_pc", {16'h0, inst_pc}, {16'h0, exp_pc});
      chk("pop_inst", {16'h0, inst_out}, {16'h0, exp_inst});
      exp_pc = exp_pc + 16'h1;
    end
    if (flush) exp_pc = flush_pc;
    tick();
  endtask

  initial begin
    reset = 1'b0; en = 1'b1; flush = 1'b0; flush_pc = 16'h0;
    inst_ready = 1'b0; mem_data = 16'h0;
    tick(); tick();
    #1;
    chk("rst_req",   {31'h0, mem_req},    32'h0);
    chk("rst_addr",  {16'h0, mem_addr},   32'h0);
    chk("rst_vld",   {31'h0, inst_valid}, 32'h0);
    chk("rst_inst",  {16'h0, inst_out},   32'h0);
    chk("rst_pc",    {16'h0, inst_pc},    32'h0);
    chk("rst_cnt",   {29'h0, count},      32'h0);

    // Stream from reset release
    reset = 1'b1; inst_ready = 1'b1;
    #1;
    chk("c0_req",  {31'h0, mem_req},    32'h1);
    chk("c0_addr", {16'h0, mem_addr},   32'h0);
    chk("c0_vld",  {31'h0, inst_valid}, 32'h0);
    step();
    #1;
    chk("c1_addr", {16'h0, mem_addr},   32'h1);
    chk("c1_vld",  {31'h0, inst_valid}, 32'h0);
    step();
    #1;
    chk("c2_vld",  {31'h0, inst_valid}, 32'h1);
    chk("c2_pc",   {16'h0, inst_pc},    32'h0);
    step();
    repeat (5) step();

    // Backpressure until full, then release
    inst_ready = 1'b0;
    repeat (6) step();
    #1;
    chk("full_cnt", {29'h0, count},   32'h4);
    chk("full_req", {31'h0, mem_req}, 32'h0);
    step();
    inst_ready = 1'b1;
    #1;
    chk("resume_req", {31'h0, mem_req},    32'h1);
    chk("resume_vld", {31'h0, inst_valid}, 32'h1);
    step();
    repeat (4) step();

    // Flush with three buffered words and one in flight
    #1;
    chk("pre_flush_cnt", {29'h0, count}, 32'h3);
    flush = 1'b1; flush_pc = 16'h0040;
    #1;
    chk("flush_req", {31'h0, mem_req}, 32'h0);
    step();
    flush = 1'b0;
    #1;
    chk("fl1_cnt",  {29'h0, count},      32'h0);
    chk("fl1_vld",  {31'h0, inst_valid}, 32'h0);
    chk("fl1_addr", {16'h0, mem_addr},   32'h40);
    chk("fl1_req",  {31'h0, mem_req},    32'h1);
    step();
    #1;
    chk("fl2_vld", {31'h0, inst_valid}, 32'h0);
    step();
    #1;
    chk("fl3_vld", {31'h0, inst_valid}, 32'h1);
    chk("fl3_pc",  {16'h0, inst_pc},    32'h40);
    step();
    repeat (3) step();

    // Address wrap-around
    flush = 1'b1; flush_pc = 16'hFFFE;
    step();
    flush = 1'b0;
    repeat (4) step();
    #1;
    chk("wrap_pc", {16'h0, inst_pc}, 32'h0);
    step();
    repeat (2) step();

    // Fetch enable gating
    en = 1'b0;
    #1;
    chk("en_req0", {31'h0, mem_req}, 32'h0);
    step();
    repeat (3) step();
    #1;
    chk("en_empty_vld",  {31'h0, inst_valid}, 32'h0);
    chk("en_empty_inst", {16'h0, inst_out},   32'h0);
    chk("en_req4",       {31'h0, mem_req},    32'h0);
    step();
    en = 1'b1;
    repeat (5) step();

    // Reset in the middle of operation
    inst_ready = 1'b0;
    step();
    #1;
    chk("pre_rst_cnt", {29'h0, count}, 32'h2);
    reset = 1'b0;
    step();
    #1;
    chk("mid_rst_req",  {31'h0, mem_req},    32'h0);
    chk("mid_rst_addr", {16'h0, mem_addr},   32'h0);
    chk("mid_rst_vld",  {31'h0, inst_valid}, 32'h0);
    chk("mid_rst_inst", {16'h0, inst_out},   32'h0);
    chk("mid_rst_pc",   {16'h0, inst_pc},    32'h0);
    chk("mid_rst_cnt",  {29'h0, count},      32'h0);
    reset = 1'b1; inst_ready = 1'b1; exp_pc = 16'h0;
    #1;
    chk("rs0_req",  {31'h0, mem_req},  32'h1);
    chk("rs0_addr", {16'h0, mem_addr}, 32'h0);
    step();
    step();
    #1;
    chk("rs2_vld", {31'h0, inst_valid}, 32'h1);
    chk("rs2_pc",  {16'h0, inst_pc},    32'h0);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
